// File: rtl/regfile_wb_queue.sv
// Writeback queue: buffers execution-unit results and drains them into the 32x32 register file write port, with read forwarding.
// Latency: a request accepted on edge N can be written to the file at edge N+1 at the earliest; the write-port outputs are combinational from the head entry.
// Backpressure: in_ready drops when the queue is full, unless the queue is draining in the same cycle; requests to r0 are consumed and never enqueued.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_rd,
   input  logic [31:0]      in_data,
   input  logic             drain_en,
   output logic             regWr,
   output logic [4:0]       rW,
   output logic [31:0]      busW,
   input  logic [4:0]       rS1,
   input  logic [4:0]       rS2,
   output logic             fwdA_hit,
   output logic [31:0]      fwdA_data,
   output logic             fwdB_hit,
   output logic [31:0]      fwdB_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Circular buffer storage; entry validity is implied by head pointer and occupancy.
   logic [4:0]       rd_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   logic [32:0]      lookup_a;
   logic [32:0]      lookup_b;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = drain_en & ~empty;
   assign in_ready = ~full | pop;
   // r0 is hard-wired zero, so such writes are handshaked but dropped.
   assign push     = in_valid & in_ready & (in_rd != 5'd0);
   assign count    = count_q;

   // Scan valid entries oldest to newest so the newest match wins; returns {hit, data}.
   function automatic logic [32:0] fwd_lookup(input logic [4:0] rs);
      logic [32:0]      res;
      logic [PTR_W-1:0] idx;
      res = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (rs != 5'd0) && (rd_q[idx] == rs)) begin
            res = {1'b1, data_q[idx]};
         end
      end
      return res;
   endfunction

   // Forwarding covers every queued entry, including the head being popped this cycle.
   always_comb begin
      lookup_a  = fwd_lookup(rS1);
      lookup_b  = fwd_lookup(rS2);
      fwdA_hit  = lookup_a[32];
      fwdA_data = lookup_a[31:0];
      fwdB_hit  = lookup_b[32];
      fwdB_data = lookup_b[31:0];
   end

   // Register-file write port driven straight from the head entry when popping.
   always_comb begin
      regWr = 1'b0;
      rW    = '0;
      busW  = '0;
      if (pop) begin
         regWr = 1'b1;
         rW    = rd_q[head_q];
         busW  = data_q[head_q];
      end
   end

   // Next-state for pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset empties the queue and discards pending writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage written at the tail on push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else if (push) begin
         rd_q[tail_q]   <= in_rd;
         data_q[tail_q] <= in_data;
      end
   end

   // Producer must hold the request stable while it is stalled.
   property p_hold_when_stalled;
      @(posedge clk) disable iff (!rst_n)
         (in_valid && !in_ready) |=> ($stable(in_rd) && $stable(in_data));
   endproperty
   a_hold_when_stalled: assert property (p_hold_when_stalled);

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_data;
   logic        drain_en;
   logic        regWr;
   logic [4:0]  rW;
   logic [31:0] busW;
   logic [4:0]  rS1;
   logic [4:0]  rS2;
   logic        fwdA_hit;
   logic [31:0] fwdA_data;
   logic        fwdB_hit;
   logic [31:0] fwdB_data;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   regfile_wb_queue #(.DEPTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rd     (in_rd),
      .in_data   (in_data),
      .drain_en  (drain_en),
      .regWr     (regWr),
      .rW        (rW),
      .busW      (busW),
      .rS1       (rS1),
      .rS2       (rS2),
      .fwdA_hit  (fwdA_hit),
      .fwdA_data (fwdA_data),
      .fwdB_hit  (fwdB_hit),
      .fwdB_data (fwdB_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_rd    = '0;
      in_data  = '0;
      drain_en = 1'b0;
      rS1      = '0;
      rS2      = '0;

      // Reset / idle
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_regWr", 32'(regWr), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_regWr", 32'(regWr), 32'd0);
      chk("idle_rW", 32'(rW), 32'd0);
      chk("idle_busW", busW, 32'd0);
      chk("idle_hitA", 32'(fwdA_hit), 32'd0);
      chk("idle_hitB", 32'(fwdB_hit), 32'd0);

      // Single write-through
      step();
      drain_en = 1'b1;
      in_valid = 1'b1;
      in_rd    = 5'd5;
      in_data  = 32'hDEADBEEF;
      rS1      = 5'd5;
      #1;
      chk("wt_ready", 32'(in_ready), 32'd1);
      chk("wt_pre_regWr", 32'(regWr), 32'd0);
      chk("wt_no_fwd_incoming", 32'(fwdA_hit), 32'd0);
      step();
      in_valid = 1'b0;
      #1;
      chk("wt_count1", 32'(count), 32'd1);
      chk("wt_regWr", 32'(regWr), 32'd1);
      chk("wt_rW", 32'(rW), 32'd5);
      chk("wt_busW", busW, 32'hDEADBEEF);
      chk("wt_hitA", 32'(fwdA_hit), 32'd1);
      chk("wt_dataA", fwdA_data, 32'hDEADBEEF);
      step();
      #1;
      chk("wt_count0", 32'(count), 32'd0);
      chk("wt_post_regWr", 32'(regWr), 32'd0);
      chk("wt_post_hitA", 32'(fwdA_hit), 32'd0);
      chk("wt_post_dataA", fwdA_data, 32'd0);

      // Fill and backpressure
      drain_en = 1'b0;
      rS1      = 5'd0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_rd    = 5'(i);
         in_data  = 32'(i * 32'h11);
         step();
      end
      in_rd   = 5'd5;
      in_data = 32'h55;
      #1;
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_ready", 32'(in_ready), 32'd0);
      step();
      #1;
      chk("stall_count", 32'(count), 32'd4);
      drain_en = 1'b1;
      #1;
      chk("drain_ready", 32'(in_ready), 32'd1);
      for (int i = 1; i <= 5; i++) begin
         chk("order_regWr", 32'(regWr), 32'd1);
         chk("order_rW", 32'(rW), 32'(i));
         chk("order_busW", busW, 32'(i * 32'h11));
         step();
         in_valid = 1'b0;
         #1;
         chk("order_count", 32'(count), (i == 1) ? 32'd4 : 32'(5 - i));
      end
      chk("drained_regWr", 32'(regWr), 32'd0);

      // Newest-match forwarding
      drain_en = 1'b0;
      in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hA; step();
      in_rd = 5'd3; in_data = 32'hB; step();
      in_rd = 5'd7; in_data = 32'hC; step();
      in_valid = 1'b0;
      rS1 = 5'd7;
      rS2 = 5'd3;
      #1;
      chk("fwd_count", 32'(count), 32'd3);
      chk("fwd_hitA", 32'(fwdA_hit), 32'd1);
      chk("fwd_dataA_newest", fwdA_data, 32'hC);
      chk("fwd_hitB", 32'(fwdB_hit), 32'd1);
      chk("fwd_dataB", fwdB_data, 32'hB);
      rS1 = 5'd0;
      rS2 = 5'd9;
      #1;
      chk("fwd_r0_hitA", 32'(fwdA_hit), 32'd0);
      chk("fwd_r0_dataA", fwdA_data, 32'd0);
      chk("fwd_miss_hitB", 32'(fwdB_hit), 32'd0);
      chk("fwd_miss_dataB", fwdB_data, 32'd0);
      // Drain in order; the popping head still forwards.
      drain_en = 1'b1;
      rS1 = 5'd7;
      rS2 = 5'd3;
      #1;
      chk("fq_rW0", 32'(rW), 32'd7);
      chk("fq_busW0", busW, 32'hA);
      chk("fq_dataA_newest", fwdA_data, 32'hC);
      step();
      #1;
      chk("fq_rW1", 32'(rW), 32'd3);
      chk("fq_busW1", busW, 32'hB);
      chk("fq_head_hitB", 32'(fwdB_hit), 32'd1);
      chk("fq_head_dataB", fwdB_data, 32'hB);
      step();
      #1;
      chk("fq_rW2", 32'(rW), 32'd7);
      chk("fq_busW2", busW, 32'hC);
      chk("fq_hitB_gone", 32'(fwdB_hit), 32'd0);
      step();
      #1;
      chk("fq_empty", 32'(count), 32'd0);

      // r0 discard
      in_valid = 1'b1;
      in_rd    = 5'd0;
      in_data  = 32'hFFFFFFFF;
      rS1      = 5'd0;
      #1;
      chk("r0_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      #1;
      chk("r0_count", 32'(count), 32'd0);
      chk("r0_regWr", 32'(regWr), 32'd0);
      chk("r0_hitA", 32'(fwdA_hit), 32'd0);

      // Async reset mid-operation
      drain_en = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1;
         in_rd    = 5'(i);
         in_data  = 32'h100 + 32'(i);
         step();
      end
      in_valid = 1'b0;
      drain_en = 1'b1;
      rS1      = 5'd2;
      #1;
      chk("ar_pre_count", 32'(count), 32'd3);
      chk("ar_pre_regWr", 32'(regWr), 32'd1);
      chk("ar_pre_rW", 32'(rW), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_regWr", 32'(regWr), 32'd0);
      chk("ar_rW", 32'(rW), 32'd0);
      chk("ar_busW", busW, 32'd0);
      chk("ar_hitA", 32'(fwdA_hit), 32'd0);
      chk("ar_ready", 32'(in_ready), 32'd1);
      step();
      #1;
      chk("ar_hold_regWr", 32'(regWr), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ar_no_stale_regWr", 32'(regWr), 32'd0);
         chk("ar_no_stale_count", 32'(count), 32'd0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
Writeback initiator for the 32x32 register file, driving its write port (regWr, rW, busW). It accepts writeback results from the execution units over a valid/ready handshake and buffers them in a small in-order FIFO. It drains the FIFO into the register file at one write per cycle whenever the file's write port is granted. For the rS1/rS2 read ports it provides forwarding lookup against writes still queued, so readers never see stale data.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 3, width of occupancy count (log2(DEPTH)+1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  writeback request valid
in_ready  out  1  request accepted on edge when in_valid & in_ready
in_rd  in  5  destination register index
in_data  in  32  write data
drain_en  in  1  register-file write port granted this cycle
regWr  out  1  register-file write enable
rW  out  5  register-file write index
busW  out  32  register-file write data
rS1  in  5  read index A, forwarding lookup
rS2  in  5  read index B, forwarding lookup
fwdA_hit  out  1  queued write pending for rS1
fwdA_data  out  32  newest queued data for rS1
fwdB_hit  out  1  queued write pending for rS2
fwdB_data  out  32  newest queued data for rS2
count  out  CNT_W  current occupancy

Behaviour:
- Reset (rst_n low, async): FIFO empty, head and tail pointers 0, count=0. All entries are invalid.
- Reset outputs: regWr=0, rW=0, busW=0, fwd*_hit=0, fwd*_data=0, in_ready=1.
- Reset asserted mid-operation discards all queued writes. No regWr pulse occurs while rst_n is low.
- Storage: circular buffer of {rd[4:0], data[31:0]}. Pointers wrap modulo DEPTH.
- Full is count==DEPTH. Empty is count==0.
- Pop condition: pop = drain_en & !empty.
- Drive when pop=1: regWr=1, rW=head.rd, busW=head.data (combinational from head).
- Drive when pop=0: regWr=0, rW=0, busW=0.
- The entry is removed on the same rising edge the register file captures it.
- in_ready = !full | pop. Combinational; a full queue accepts when draining in the same cycle.
- Push condition: push = in_valid & in_ready & (in_rd != 0).
- Requests with in_rd==0 are handshaked (consumed) but never enqueued, since r0 is hard-wired zero.
- count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a request accepted on edge N is written to the register file no earlier than edge N+1 (empty queue, drain_en high at N+1).
- Ordering: strictly FIFO. Two queued writes to the same rd are written oldest first.
- Forwarding lookup is combinational over valid entries only:
  - hit when entry.rd == rS and rS != 0.
  - When several entries match, data comes from the newest (closest to tail).
  - No hit gives fwd*_hit=0 and fwd*_data=0.
- The head entry being popped this cycle still counts as a hit. The register file updates only at the edge, so forwarding must cover it.
- The incoming request (in_valid) is not forwarded until it is enqueued.
- in_data/in_rd may change freely while in_valid is low. While in_valid & !in_ready, the producer holds them stable (protocol rule, checked by assertion).

Test Plan:
- Reset/idle: rst_n low then high, no stimulus -> count=0, in_ready=1, regWr=0, rW=0, busW=0, hits=0.
- Single write-through: drain_en=1, push rd=5 data=0xDEADBEEF at edge N -> at N+1 regWr=1, rW=5, busW=0xDEADBEEF; count 1 then 0; fwdA_hit=1 for rS1=5 during that cycle.
- Fill and backpressure:
  - drain_en=0, push rd=1..4 data=0x11..0x44 -> count=4, in_ready=0; a 5th request stalls.
  - Raise drain_en -> in_ready=1 with simultaneous push/pop, count stays 4; writes emerge rd=1,2,3,4,5 in order.
- Newest-match forwarding:
  - drain_en=0, queue rd=7/0xA, rd=3/0xB, rd=7/0xC.
  - rS1=7, rS2=3 -> fwdA_hit=1, fwdA_data=0xC; fwdB_hit=1, fwdB_data=0xB.
  - rS1=0 -> fwdA_hit=0.
- r0 discard: push rd=0 data=0xFFFFFFFF with queue empty -> handshake completes, count stays 0, no regWr pulse.
- Async reset mid-operation: queue 3 entries, drop rst_n between clock edges -> count=0 and regWr=0 immediately. After release, no stale writes with drain_en=1.
